// File: rtl/control_responder.sv
// -----------------------------------------------------------------------------
// control_responder
//   Strobe-sequenced unsigned multiplier. A sequencer loads operand A (sel1),
//   then operand B (sel2), then requests the product (mux1). Any out-of-order
//   or overlapping strobe sets a sticky error flag and abandons the operation.
//
// Ports
//   clk     in   1    clock, rising edge
//   rst     in   1    synchronous reset, active low
//   sel1    in   1    load operand A from din
//   sel2    in   1    load operand B from din
//   mux1    in   1    latch A*B into result
//   din     in   W    shared operand bus
//   result  out  2W   registered unsigned product
//   done    out  1    one-cycle pulse when result updates
//   busy    out  1    operation in progress (A or A+B held)
//   err     out  1    sticky protocol-violation flag
//   count   out  8    completed operations, wraps at 256
// -----------------------------------------------------------------------------
module control_responder #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sel1,
    input  logic           sel2,
    input  logic           mux1,
    input  logic [W-1:0]   din,
    output logic [2*W-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           err,
    output logic [7:0]     count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] result_q, result_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [7:0]     count_q, count_d;

    logic [1:0]     nstrb;
    logic           exp_strb;

    assign nstrb = {1'b0, sel1} + {1'b0, sel2} + {1'b0, mux1};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        count_d  = count_q;
        exp_strb = 1'b0;

        case (state_q)
            IDLE:    exp_strb = sel1;
            HAVE_A:  exp_strb = sel2;
            HAVE_B:  exp_strb = mux1;
            default: exp_strb = 1'b0;
        endcase

        if (state_q != IDLE && state_q != HAVE_A && state_q != HAVE_B) begin
            // Unreachable encoding: recover silently, outputs untouched.
            state_d = IDLE;
        end else if (nstrb == 2'd0) begin
            // hold
        end else if (nstrb == 2'd1 && exp_strb) begin
            case (state_q)
                IDLE: begin
                    a_d     = din;
                    state_d = HAVE_A;
                end
                HAVE_A: begin
                    b_d     = din;
                    state_d = HAVE_B;
                end
                default: begin
                    // Widen both operands so the product keeps all 2W bits.
                    result_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
                    done_d   = 1'b1;
                    count_d  = count_q + 8'd1;
                    state_d  = IDLE;
                end
            endcase
        end else begin
            // Overlapping or out-of-order strobe: abandon, no loads.
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q == HAVE_A) || (state_q == HAVE_B);
    assign err    = err_q;
    assign count  = count_q;

endmodule

// File: tb/tb_control_responder.sv
// -----------------------------------------------------------------------------
// tb_control_responder
//   Directed scenarios followed by randomized strobe traffic. A reference
//   model tracks how far the A/B/multiply sequence has progressed and pushes
//   the expected {result,count} for each completed operation; a monitor pops
//   one entry per done pulse.
// -----------------------------------------------------------------------------
module tb_control_responder;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           sel1, sel2, mux1;
    logic [W-1:0]   din;
    logic [2*W-1:0] result;
    logic           done, busy, err;
    logic [7:0]     count;

    control_responder #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sel1   (sel1),
        .sel2   (sel2),
        .mux1   (mux1),
        .din    (din),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err),
        .count  (count)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;
    int ndone = 0;

    // Reference model: progress = number of operands collected (0,1,2).
    int  m_prog = 0;
    int  m_a = 0, m_b = 0;
    int  m_res = 0;
    int  m_cnt = 0;
    bit  m_err = 0;
    int  q_res[$];
    int  q_cnt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit s1, input bit s2, input bit m, input int d);
        int n;
        bit ok;
        if (!r) begin
            m_prog = 0; m_a = 0; m_b = 0; m_res = 0; m_cnt = 0; m_err = 0;
            return;
        end
        n  = int'(s1) + int'(s2) + int'(m);
        ok = (m_prog == 0 && s1) || (m_prog == 1 && s2) || (m_prog == 2 && m);
        if (n == 0) return;
        if (n > 1 || !ok) begin
            m_err  = 1;
            m_prog = 0;
            return;
        end
        if (m_prog == 0) begin
            m_a = d; m_prog = 1;
        end else if (m_prog == 1) begin
            m_b = d; m_prog = 2;
        end else begin
            m_res  = m_a * m_b;
            m_cnt  = (m_cnt + 1) % 256;
            m_prog = 0;
            q_res.push_back(m_res);
            q_cnt.push_back(m_cnt);
        end
    endtask

    task automatic step(input bit r, input bit s1, input bit s2, input bit m, input int d);
        @(negedge clk);
        rst  = r;
        sel1 = s1;
        sel2 = s2;
        mux1 = m;
        din  = W'(d);
        model(r, s1, s2, m, d);
        @(posedge clk);
        #2;
        chk("result", 32'(result), 32'(m_res));
        chk("count",  32'(count),  32'(m_cnt));
        chk("err",    32'(err),    32'(m_err));
        chk("busy",   32'(busy),   32'(m_prog != 0));
        // The monitor must already have consumed any completed operation.
        chk("done_pending", 32'(q_res.size()), 32'd0);
        if (q_res.size() != 0) begin
            q_res.delete();
            q_cnt.delete();
        end
    endtask

    task automatic op(input int a, input int b);
        step(1, 1, 0, 0, a);
        step(1, 0, 1, 0, b);
        step(1, 0, 0, 1, 0);
    endtask

    // Monitor: one scoreboard entry per done pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (q_res.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("sb_result", 32'(result), 32'(q_res.pop_front()));
                    chk("sb_count",  32'(count),  32'(q_cnt.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; sel1 = 1'b0; sel2 = 1'b0; mux1 = 1'b0; din = '0;

        // Reset state, with strobes asserted to show reset priority.
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 77);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_count",  32'(count),  32'd0);

        // Nominal 12 * 11.
        op(12, 11);
        chk("nominal_result", 32'(result), 32'd132);
        chk("nominal_count",  32'(count),  32'd1);
        chk("nominal_err",    32'(err),    32'd0);
        step(1, 0, 0, 0, 0);
        chk("done_one_cycle", 32'(done), 32'd0);

        // Max operands, full product width.
        op(255, 255);
        chk("max_result", 32'(result), 32'hFE01);

        // Back-to-back: sel1 directly after the mux1 edge.
        op(7, 9);
        op(2, 3);
        chk("b2b_result", 32'(result), 32'd6);

        // Order error, then a valid sequence while err stays set.
        step(1, 0, 1, 0, 99);
        chk("order_err",  32'(err),  32'd1);
        chk("order_busy", 32'(busy), 32'd0);
        op(3, 4);
        chk("after_err_result", 32'(result), 32'd12);
        chk("after_err_err",    32'(err),    32'd1);

        // Simultaneous strobes in IDLE: A must not load.
        step(0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 200);
        chk("simul_err",  32'(err),  32'd1);
        chk("simul_busy", 32'(busy), 32'd0);
        step(1, 0, 0, 0, 0);

        // Reset mid-operation.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 5);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("midrst_err",    32'(err),    32'd1);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_count",  32'(count),  32'd0);

        // Count wrap after 256 operations from reset.
        step(0, 0, 0, 0, 0);
        ndone = 0;
        for (int i = 0; i < 256; i++) op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        step(1, 0, 0, 0, 0);
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_dones", 32'(ndone), 32'd256);

        // Randomized traffic biased toward legal sequences.
        for (int i = 0; i < 3000; i++) begin
            int  mode;
            bit  r, s1, s2, m;
            r    = ($urandom_range(0, 99) != 0);
            mode = int'($urandom_range(0, 9));
            s1 = 0; s2 = 0; m = 0;
            if (mode >= 4 && mode <= 7) begin
                if (m_prog == 0) s1 = 1;
                else if (m_prog == 1) s2 = 1;
                else m = 1;
            end else if (mode == 8) begin
                case ($urandom_range(0, 2))
                    0: s1 = 1;
                    1: s2 = 1;
                    default: m = 1;
                endcase
            end else if (mode == 9) begin
                s1 = 1'($urandom_range(0, 1));
                s2 = 1'($urandom_range(0, 1));
                m  = 1'($urandom_range(0, 1));
            end
            step(r, s1, s2, m, int'($urandom_range(0, 255)));
        end
        step(1, 0, 0, 0, 0);
        chk("sb_empty", 32'(q_res.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
